// File: rtl/seq_alu.sv
// Clocked N-bit ALU with a start/busy/done handshake, iterative shift-add MUL and restoring DIV/MOD.
// Optional macro SEQ_ALU_EARLY_TERM_EN: MUL finishes as soon as the remaining multiplier bits are zero.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           operator,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 err
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_MOD = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_ITER = 2'd2, S_DONE = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [3:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, sh_q, sh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;

  logic [WIDTH:0]       add_sum, sub_diff;
  logic [2*WIDTH-1:0]   calc_res;
  logic                 calc_n, calc_z, calc_c, calc_v, calc_err;
  logic [2*WIDTH-1:0]   mul_acc, iter_res;
  logic [WIDTH:0]       rem_sh, rem_diff;
  logic [WIDTH-1:0]     rem_nx, quo_nx;
  logic                 iter_last, long_op;

  // Single-cycle results; divide-by-zero is the only way DIV/MOD reach this path.
  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    calc_res = '0;
    calc_n   = 1'b0;
    calc_c   = 1'b0;
    calc_v   = 1'b0;
    calc_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        calc_res = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
        calc_n   = add_sum[WIDTH-1];
        calc_c   = add_sum[WIDTH];
        calc_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        calc_res = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
        calc_n   = sub_diff[WIDTH-1];
        calc_c   = sub_diff[WIDTH];
        calc_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_DIV: begin
        calc_res = '1;
        calc_v   = 1'b1;
        calc_err = 1'b1;
      end
      OP_MOD: begin
        calc_res = {{WIDTH{1'b0}}, a_q};
        calc_v   = 1'b1;
        calc_err = 1'b1;
      end
      OP_AND: begin
        calc_res = {{WIDTH{1'b0}}, a_q & b_q};
        calc_n   = a_q[WIDTH-1] & b_q[WIDTH-1];
      end
      OP_OR: begin
        calc_res = {{WIDTH{1'b0}}, a_q | b_q};
        calc_n   = a_q[WIDTH-1] | b_q[WIDTH-1];
      end
      OP_XOR: begin
        calc_res = {{WIDTH{1'b0}}, a_q ^ b_q};
        calc_n   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
      end
      OP_SHL:  calc_res = {{WIDTH{1'b0}}, a_q} << b_q;
      OP_SHR:  calc_res = {{WIDTH{1'b0}}, a_q >> b_q};
      default: calc_err = 1'b1;
    endcase
    calc_z = (calc_res == '0) && (op_q <= OP_SHR);
  end

  // One shift-add or restoring-divide step; a negative trial difference means "do not subtract".
  always_comb begin
    mul_acc  = b_q[0] ? (acc_q + sh_q) : acc_q;
    rem_sh   = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    rem_nx   = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    quo_nx   = {sh_q[WIDTH-2:0], ~rem_diff[WIDTH]};
`ifdef SEQ_ALU_EARLY_TERM_EN
    iter_last = (cnt_q == CNT_W'(WIDTH - 1)) ||
                ((op_q == OP_MUL) && (b_q[WIDTH-1:1] == '0));
`else
    iter_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif
    case (op_q)
      OP_MUL:  iter_res = mul_acc;
      OP_DIV:  iter_res = {{WIDTH{1'b0}}, quo_nx};
      default: iter_res = {{WIDTH{1'b0}}, rem_nx};
    endcase
    long_op = (operator == OP_MUL) ||
              (((operator == OP_DIV) || (operator == OP_MOD)) && (b != '0));
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = operator;
          acc_d   = '0;
          sh_d    = {{WIDTH{1'b0}}, a};
          cnt_d   = '0;
          state_d = long_op ? S_ITER : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        result_d = calc_res;
        n_d      = calc_n;
        z_d      = calc_z;
        c_d      = calc_c;
        v_d      = calc_v;
        err_d    = calc_err;
        state_d  = S_DONE;
      end
      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          sh_d  = {sh_q[2*WIDTH-2:0], 1'b0};
          b_d   = {1'b0, b_q[WIDTH-1:1]};
        end else begin
          acc_d = {{WIDTH{1'b0}}, rem_nx};
          sh_d  = {{WIDTH{1'b0}}, quo_nx};
        end
        if (iter_last) begin
          result_d = iter_res;
          n_d      = 1'b0;
          z_d      = (iter_res == '0);
          c_d      = 1'b0;
          v_d      = 1'b0;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d  = S_ITER;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_ITER);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 4'h0;
      acc_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_n = n_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
  assign err    = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=4): directed test-plan vectors, handshake/reset cases and random ops
// checked against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 4;
  localparam longint M = longint'(1) << W;

  logic           clk = 1'b0;
  logic           rst_n, start;
  logic [W-1:0]   a, b;
  logic [3:0]     operator;
  logic           busy, done, flag_n, flag_z, flag_c, flag_v, err;
  logic [2*W-1:0] result;
  int             checks = 0, passes = 0, fails = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .operator(operator),
    .busy(busy), .done(done), .result(result), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sgn(input longint x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic logic oor(input longint r);
    return (r < -(M / 2)) || (r > M / 2 - 1);
  endfunction

  // Reference: what each opcode means arithmetically, and how many cycles it should take.
  function automatic void ref_op(input logic [3:0] op, input longint av, input longint bv,
                                 output longint res, output logic n, output logic z,
                                 output logic c, output logic v, output logic e, output int lat);
    longint s, t;
    int k;
    res = 0; n = 1'b0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1;
    case (op)
      4'd0: begin s = av + bv; res = s % M; c = (s >= M); v = oor(sgn(av) + sgn(bv)); end
      4'd1: begin s = av - bv; res = (s + M) % M; c = (av < bv); v = oor(sgn(av) - sgn(bv)); end
      4'd2: begin
        res = av * bv;
`ifdef SEQ_ALU_EARLY_TERM_EN
        k = 0; t = bv;
        while (t != 0) begin t = t >> 1; k++; end
        lat = (k < 1) ? 1 : k;
`else
        lat = W;
`endif
      end
      4'd3: if (bv == 0) begin res = M * M - 1; v = 1'b1; e = 1'b1; end
            else begin res = av / bv; lat = W; end
      4'd4: if (bv == 0) begin res = av; v = 1'b1; e = 1'b1; end
            else begin res = av % bv; lat = W; end
      4'd5: res = av & bv;
      4'd6: res = av | bv;
      4'd7: res = av ^ bv;
      4'd8: res = (bv >= 2 * W) ? 0 : (av << bv) % (M * M);
      4'd9: res = (bv >= W) ? 0 : av >> bv;
      default: e = 1'b1;
    endcase
    n = (op inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd7}) ? res[W-1] : 1'b0;
    z = (op <= 4'd9) && (res == 0);
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    start = 1'b1; operator = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv);
    longint er; logic en, ez, ec, ev, ee; int el, lat;
    run_op(op, av, bv, lat);
    ref_op(op, longint'(av), longint'(bv), er, en, ez, ec, ev, ee, el);
    check($sformatf("%s.lat", tag), lat, el);
    check($sformatf("%s.res", tag), result, er);
    check($sformatf("%s.flags", tag), {flag_n, flag_z, flag_c, flag_v}, {en, ez, ec, ev});
    check($sformatf("%s.err", tag), err, ee);
    check($sformatf("%s.busy", tag), busy, 1'b0);
  endtask

  logic [3:0] p_op [15] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h4, 4'h3, 4'h4,
                            4'h8, 4'h8, 4'h9, 4'hB, 4'h5};
  logic [3:0] p_a  [15] = '{4'h6, 4'hC, 4'hF, 4'h3, 4'hF, 4'hD, 4'hD, 4'h9, 4'hD, 4'hD,
                            4'h2, 4'hF, 4'hF, 4'h5, 4'h5};
  logic [3:0] p_b  [15] = '{4'h9, 4'hD, 4'hF, 4'h5, 4'hF, 4'h0, 4'h2, 4'h6, 4'h0, 4'h0,
                            4'h3, 4'h7, 4'h3, 4'h3, 4'h3};
  logic [7:0] p_res[15] = '{8'h0F, 8'h09, 8'h00, 8'h0E, 8'hE1, 8'h00, 8'h06, 8'h03, 8'hFF, 8'h0D,
                            8'h10, 8'h80, 8'h01, 8'h00, 8'h01};

  initial begin
    int lat, cyc;
    logic seen_done;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; operator = 4'h0;
    repeat (2) @(negedge clk);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.result", result, 0);
    check("rst.flags", {flag_n, flag_z, flag_c, flag_v, err}, 5'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      check_op($sformatf("plan%0d", i), p_op[i], p_a[i], p_b[i]);
      check($sformatf("plan%0d.const", i), result, p_res[i]);
    end

    // A start pulse while MUL is busy must not be taken.
    @(negedge clk);
    start = 1'b1; operator = 4'h2; a = 4'hF; b = 4'hF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; operator = 4'h0; a = 4'h1; b = 4'h1;
    check("ign.busy", busy, 1'b1);
    @(negedge clk);
    start = 1'b0; cyc = 2;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    check("ign.lat", cyc, W);
    check("ign.res", result, 8'hE1);
    @(negedge clk);
    check("ign.idle", {busy, done}, 2'b00);
    check("ign.res_held", result, 8'hE1);

    // start held in the DONE cycle launches the next op with no gap.
    start = 1'b1; operator = 4'h0; a = 4'h3; b = 4'h4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("b2b.done1", done, 1'b1);
    check("b2b.res1", result, 8'h07);
    start = 1'b1; operator = 4'h1; a = 4'h5; b = 4'h2;
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy", {busy, done}, 2'b10);
    @(negedge clk);
    check("b2b.done2", done, 1'b1);
    check("b2b.res2", result, 8'h03);

    // Reset in the middle of a MUL.
    @(negedge clk);
    start = 1'b1; operator = 4'h2; a = 4'hD; b = 4'hB;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst.outs", {busy, done, flag_n, flag_z, flag_c, flag_v, err}, 7'b0);
    check("mrst.result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin @(negedge clk); seen_done = seen_done | done; end
    check("mrst.no_done", seen_done, 1'b0);
    check_op("mrst.after", 4'h2, 4'hD, 4'hB);

    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      check_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
